emmc_ddr_lane_shifter: RTL and testbench
========================================

EMMC_DDR_LANE_SHIFTER -- requirements
Module: emmc_ddr_lane_shifter

Interface
REQ-001 SHALL use one clock, Clk; Reset is asynchronous, active-high.
REQ-002 SHALL have parameter LANES, default 8, data lanes (1, 4 or 8).
REQ-003 SHALL have parameter WORD_BITS, default 8, bits per lane per word (even, >=4).
REQ-004 SHALL have port Clk  in  1  clock.
REQ-005 SHALL have port Reset  in  1  async active-high reset.
REQ-006 SHALL have port DdrMode  in  1  1=DDR, 0=SDR; sampled only when a frame starts.
REQ-007 SHALL have port TxData  in  LANES*WORD_BITS  lane i at [i*WORD_BITS +: WORD_BITS], MSB first.
REQ-008 SHALL have port TxValid  in  1  word available.
REQ-009 SHALL have port TxLast  in  1  qualifies final word of frame.
REQ-010 SHALL have port TxReady  out  1  word accepted when TxValid&&TxReady.
REQ-011 SHALL have port TxUnderrun  out  1  one-cycle pulse, frame aborted.
REQ-012 SHALL have port WriteData_posEdge  out  LANES  bit for rising-edge half of DDR output cell.
REQ-013 SHALL have port WriteData_negEdge  out  LANES  bit for falling-edge half.
REQ-014 SHALL have port DriveEnable  out  1  high while a TX frame is on the lines.
REQ-015 SHALL have port ReadData_posEdge  in  LANES  rising-edge sample from DDR input cell.
REQ-016 SHALL have port ReadData_negEdge  in  LANES  falling-edge sample.
REQ-017 SHALL have port RxArm  in  1  pulse: start hunting for a start bit.
REQ-018 SHALL have port RxWordCount  in  10  words to receive, sampled with RxArm (0 = 1024).
REQ-019 SHALL have port RxData  out  LANES*WORD_BITS  received word, same packing as TxData.
REQ-020 SHALL have port RxValid  out  1  one-cycle pulse, RxData valid.
REQ-021 SHALL have port RxDone  out  1  one-cycle pulse, frame end evaluated.
REQ-022 SHALL have port RxErr  out  2  {crc_err, end_bit_err}, valid with RxDone.

Function
REQ-023 TX FSM SHALL have states TX_IDLE, TX_START, TX_DATA, TX_CRC, TX_END; all outputs registered.
REQ-024 TX_IDLE: TxReady=1, DriveEnable=0, both WriteData buses all-ones; accept at cycle n -> TX_START at n+1 (all lanes 0 both edges, DriveEnable=1).
REQ-025 TX_DATA DDR: per clock, pos=bit k, neg=bit k-1, MSB first; WORD_BITS/2 clocks per word.
REQ-026 TX_DATA SDR: one bit per clock, neg=pos; WORD_BITS clocks per word.
REQ-027 TxReady SHALL be high during the final clock of a non-last word so back-to-back words leave no gap.
REQ-028 No TxValid at a word boundary of a non-last word: assert TxUnderrun, go to TX_END.
REQ-029 TX_END: one clock all lanes 1 both edges, DriveEnable=1; then TX_IDLE.
REQ-030 RX FSM SHALL have states RX_IDLE, RX_HUNT, RX_DATA, RX_CRC, RX_END; RxArm ignored outside RX_IDLE.
REQ-031 RX_HUNT: start bit = all lanes ReadData_posEdge==0; first data sampled the following clock, mode per REQ-025/026 (SDR uses posEdge only).
REQ-032 RxValid SHALL pulse one cycle after the word's last bits are sampled; counter wraps after RxWordCount words into RX_CRC or RX_END.
REQ-033 RX_END: end_bit_err=1 if any lane posEdge!=1; RxDone pulses next cycle; return RX_IDLE.
REQ-034 TX and RX SHALL operate independently and concurrently.

Reset
REQ-035 Reset SHALL force TX_IDLE, RX_IDLE, TxReady=1, DriveEnable=0, WriteData buses all-ones, RxData=0, all pulses and RxErr 0.
REQ-036 Reset mid-frame SHALL abort immediately; no end bit, no RxDone.

Configuration
REQ-037 With EMMC_LANE_CRC_EN defined: per-lane CRC16 (x^16+x^12+x^5+1, init 0) over data bits; DDR keeps separate pos/neg CRCs; TX_CRC/RX_CRC last 16 clocks, MSB first; mismatch sets crc_err.
REQ-038 Without EMMC_LANE_CRC_EN: no CRC states, end bit directly follows data, crc_err tied 0.

Verification
REQ-039 LANES=4, SDR, one word 0xA5 all lanes, no CRC -> pos=neg: 0,1,0,1,0,0,1,0,1,1; DriveEnable high exactly 10 cycles.
REQ-040 DDR, lane0 word 0xB4 -> start, then (pos,neg)=(1,0),(1,1),(0,1),(0,0), end; 6 active clocks.
REQ-041 Two words, TxValid held, second with TxLast -> no idle clock between words; TxReady high on cycle 4 of word 1.
REQ-042 TxValid dropped after word 1 (no TxLast) -> TxUnderrun pulse, end bit, TX_IDLE.
REQ-043 LANES=1, SDR, CRC_EN, 512 words 0xFF -> CRC 0x7FA1 transmitted; RX loopback RxErr=00, 512 RxValid pulses.
REQ-044 RX DDR, RxWordCount=2, end bit driven 0 on lane 2 -> 2 RxValid, RxDone with RxErr=01.

Source files
------------

// File: rtl/emmc_ddr_lane_shifter.sv
// emmc_ddr_lane_shifter
//   Parallel-word to multi-lane serial shifter for an eMMC-style data bus,
//   with independent transmit and receive framers. Each frame is a start bit
//   (all lanes 0), MSB-first data words, an optional per-lane CRC16, and an
//   end bit (all lanes 1). In DDR mode every clock carries two bits per lane
//   (rising-edge half = bit k, falling-edge half = bit k-1). In SDR mode it
//   carries one bit per lane.
//
//   Optional feature: define EMMC_LANE_CRC_EN to add per-lane CRC16
//   (x^16+x^12+x^5+1, init 0) generation and checking. In DDR mode the
//   rising-edge and falling-edge streams each have their own CRC.
//
// Parameters
//   LANES      data lanes (1, 4 or 8)
//   WORD_BITS  bits per lane per word (even, >= 4)
//
// Ports
//   Clk, Reset                    clock, asynchronous active-high reset
//   DdrMode                       1=DDR, 0=SDR; sampled at TX frame start / RxArm
//   TxData/TxValid/TxLast/TxReady word stream in; lane i at [i*WORD_BITS +: WORD_BITS]
//   TxUnderrun                    pulse: frame aborted, no word at a word boundary
//   WriteData_posEdge/_negEdge    per-lane bits for the DDR output cell halves
//   DriveEnable                   high while a TX frame is on the lines
//   ReadData_posEdge/_negEdge     per-lane samples from the DDR input cell
//   RxArm, RxWordCount            start hunting; word count (0 = 1024)
//   RxData/RxValid                received word, one-cycle valid pulse
//   RxDone, RxErr                 frame-end pulse with {crc_err, end_bit_err}
module emmc_ddr_lane_shifter #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned WORD_BITS = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         DdrMode,
  input  logic [LANES*WORD_BITS-1:0]   TxData,
  input  logic                         TxValid,
  input  logic                         TxLast,
  output logic                         TxReady,
  output logic                         TxUnderrun,
  output logic [LANES-1:0]             WriteData_posEdge,
  output logic [LANES-1:0]             WriteData_negEdge,
  output logic                         DriveEnable,
  input  logic [LANES-1:0]             ReadData_posEdge,
  input  logic [LANES-1:0]             ReadData_negEdge,
  input  logic                         RxArm,
  input  logic [9:0]                   RxWordCount,
  output logic [LANES*WORD_BITS-1:0]   RxData,
  output logic                         RxValid,
  output logic                         RxDone,
  output logic [1:0]                   RxErr
);

  localparam int unsigned DW = LANES * WORD_BITS;
  localparam int unsigned CW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] SDR_LAST = CW'(WORD_BITS - 1);
  localparam logic [CW-1:0] DDR_LAST = CW'(WORD_BITS / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef EMMC_LANE_CRC_EN
    TX_CRC,
`endif
    TX_END
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_HUNT,
    RX_DATA,
`ifdef EMMC_LANE_CRC_EN
    RX_CRC,
`endif
    RX_END
  } rx_state_t;

  // Per-lane bit at the head of each lane's slice (second=1 selects the bit
  // just below the MSB, used for the falling-edge half in DDR).
  function automatic logic [LANES-1:0] lane_bits(input logic [DW-1:0] w, input logic second);
    logic [LANES-1:0] r;
    r = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      r[l] = second ? w[l*WORD_BITS + WORD_BITS - 2] : w[l*WORD_BITS + WORD_BITS - 1];
    end
    return r;
  endfunction

  // Advance every lane slice by one (SDR) or two (DDR) bits.
  function automatic logic [DW-1:0] lane_shift(input logic [DW-1:0] w, input logic two);
    logic [DW-1:0] r;
    r = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      r[l*WORD_BITS +: WORD_BITS] = two ? {w[l*WORD_BITS +: WORD_BITS-2], 2'b00}
                                        : {w[l*WORD_BITS +: WORD_BITS-1], 1'b0};
    end
    return r;
  endfunction

`ifdef EMMC_LANE_CRC_EN
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic d);
    logic fb;
    fb = c[15] ^ d;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // ---------------------------------------------------------------- TX ----
  tx_state_t        tx_state;
  logic [DW-1:0]    tx_sh;
  logic [CW-1:0]    tx_cnt;
  logic             tx_ddr;
  logic             tx_last;
  logic [CW-1:0]    tx_lastc;
  logic             tx_wrap;
  logic [DW-1:0]    tx_src;
  logic [DW-1:0]    tx_src_sh;
  logic [LANES-1:0] tx_pos;
  logic [LANES-1:0] tx_neg;

`ifdef EMMC_LANE_CRC_EN
  logic [15:0]      tx_crc_p    [LANES];
  logic [15:0]      tx_crc_n    [LANES];
  logic [15:0]      tx_crc_p_nx [LANES];
  logic [15:0]      tx_crc_n_nx [LANES];
  logic [LANES-1:0] tx_crc_pos;
  logic [LANES-1:0] tx_crc_neg;
  logic [3:0]       tx_crc_cnt;
`endif

  // At a word boundary with another word due, the next chunk comes straight
  // from TxData so consecutive words leave no gap on the lines.
  always_comb begin
    tx_lastc  = tx_ddr ? DDR_LAST : SDR_LAST;
    tx_wrap   = (tx_cnt == tx_lastc);
    tx_src    = (tx_state == TX_DATA && tx_wrap && !tx_last) ? TxData : tx_sh;
    tx_pos    = lane_bits(tx_src, 1'b0);
    tx_neg    = tx_ddr ? lane_bits(tx_src, 1'b1) : tx_pos;
    tx_src_sh = lane_shift(tx_src, tx_ddr);
  end

`ifdef EMMC_LANE_CRC_EN
  always_comb begin
    tx_crc_pos = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      tx_crc_p_nx[l] = crc16_step(tx_crc_p[l], tx_pos[l]);
      tx_crc_n_nx[l] = crc16_step(tx_crc_n[l], tx_neg[l]);
      tx_crc_pos[l]  = tx_crc_p[l][15];
    end
    tx_crc_neg = tx_pos;
    for (int unsigned l = 0; l < LANES; l++) begin
      tx_crc_neg[l] = tx_ddr ? tx_crc_n[l][15] : tx_crc_p[l][15];
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tx_state          <= TX_IDLE;
      tx_sh             <= '0;
      tx_cnt            <= '0;
      tx_ddr            <= 1'b0;
      tx_last           <= 1'b0;
      TxReady           <= 1'b1;
      TxUnderrun        <= 1'b0;
      DriveEnable       <= 1'b0;
      WriteData_posEdge <= '1;
      WriteData_negEdge <= '1;
`ifdef EMMC_LANE_CRC_EN
      tx_crc_cnt        <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        tx_crc_p[l] <= '0;
        tx_crc_n[l] <= '0;
      end
`endif
    end else begin
      TxUnderrun <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (TxValid) begin
            tx_sh             <= TxData;
            tx_ddr            <= DdrMode;
            tx_last           <= TxLast;
            TxReady           <= 1'b0;
            DriveEnable       <= 1'b1;
            WriteData_posEdge <= '0;
            WriteData_negEdge <= '0;
            tx_state          <= TX_START;
`ifdef EMMC_LANE_CRC_EN
            for (int unsigned l = 0; l < LANES; l++) begin
              tx_crc_p[l] <= '0;
              tx_crc_n[l] <= '0;
            end
`endif
          end
        end

        TX_START: begin
          WriteData_posEdge <= tx_pos;
          WriteData_negEdge <= tx_neg;
          tx_sh             <= tx_src_sh;
          tx_cnt            <= '0;
          tx_state          <= TX_DATA;
`ifdef EMMC_LANE_CRC_EN
          tx_crc_p          <= tx_crc_p_nx;
          tx_crc_n          <= tx_crc_n_nx;
`endif
        end

        TX_DATA: begin
          if (!tx_wrap) begin
            WriteData_posEdge <= tx_pos;
            WriteData_negEdge <= tx_neg;
            tx_sh             <= tx_src_sh;
            tx_cnt            <= tx_cnt + CW'(1);
            // Ready goes high while the final chunk of a non-last word is out.
            TxReady           <= ((tx_cnt + CW'(1)) == tx_lastc) && !tx_last;
`ifdef EMMC_LANE_CRC_EN
            tx_crc_p          <= tx_crc_p_nx;
            tx_crc_n          <= tx_crc_n_nx;
`endif
          end else if (!tx_last) begin
            TxReady <= 1'b0;
            if (TxValid) begin
              WriteData_posEdge <= tx_pos;
              WriteData_negEdge <= tx_neg;
              tx_sh             <= tx_src_sh;
              tx_last           <= TxLast;
              tx_cnt            <= '0;
`ifdef EMMC_LANE_CRC_EN
              tx_crc_p          <= tx_crc_p_nx;
              tx_crc_n          <= tx_crc_n_nx;
`endif
            end else begin
              TxUnderrun        <= 1'b1;
              WriteData_posEdge <= '1;
              WriteData_negEdge <= '1;
              tx_state          <= TX_END;
            end
          end else begin
            TxReady <= 1'b0;
`ifdef EMMC_LANE_CRC_EN
            WriteData_posEdge <= tx_crc_pos;
            WriteData_negEdge <= tx_crc_neg;
            for (int unsigned l = 0; l < LANES; l++) begin
              tx_crc_p[l] <= {tx_crc_p[l][14:0], 1'b0};
              tx_crc_n[l] <= {tx_crc_n[l][14:0], 1'b0};
            end
            tx_crc_cnt <= '0;
            tx_state   <= TX_CRC;
`else
            WriteData_posEdge <= '1;
            WriteData_negEdge <= '1;
            tx_state          <= TX_END;
`endif
          end
        end

`ifdef EMMC_LANE_CRC_EN
        TX_CRC: begin
          if (tx_crc_cnt == 4'd15) begin
            WriteData_posEdge <= '1;
            WriteData_negEdge <= '1;
            tx_state          <= TX_END;
          end else begin
            WriteData_posEdge <= tx_crc_pos;
            WriteData_negEdge <= tx_crc_neg;
            for (int unsigned l = 0; l < LANES; l++) begin
              tx_crc_p[l] <= {tx_crc_p[l][14:0], 1'b0};
              tx_crc_n[l] <= {tx_crc_n[l][14:0], 1'b0};
            end
            tx_crc_cnt <= tx_crc_cnt + 4'd1;
          end
        end
`endif

        TX_END: begin
          DriveEnable <= 1'b0;
          TxReady     <= 1'b1;
          tx_state    <= TX_IDLE;
        end

        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX ----
  rx_state_t     rx_state;
  logic          rx_ddr;
  logic [CW-1:0] rx_cnt;
  logic [10:0]   rx_words;
  logic [DW-1:0] rx_acc;
  logic [DW-1:0] rx_next;
  logic          rx_wrap;

`ifdef EMMC_LANE_CRC_EN
  logic [15:0]   rx_crc_p    [LANES];
  logic [15:0]   rx_crc_n    [LANES];
  logic [15:0]   rx_crc_p_nx [LANES];
  logic [15:0]   rx_crc_n_nx [LANES];
  logic [3:0]    rx_crc_cnt;
  logic          rx_crc_bad;
  logic          rx_crc_miss;
`endif

  always_comb begin
    rx_wrap = (rx_cnt == (rx_ddr ? DDR_LAST : SDR_LAST));
    rx_next = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rx_next[l*WORD_BITS +: WORD_BITS] = rx_ddr
        ? {rx_acc[l*WORD_BITS +: WORD_BITS-2], ReadData_posEdge[l], ReadData_negEdge[l]}
        : {rx_acc[l*WORD_BITS +: WORD_BITS-1], ReadData_posEdge[l]};
    end
  end

`ifdef EMMC_LANE_CRC_EN
  always_comb begin
    rx_crc_miss = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      rx_crc_p_nx[l] = crc16_step(rx_crc_p[l], ReadData_posEdge[l]);
      rx_crc_n_nx[l] = crc16_step(rx_crc_n[l], ReadData_negEdge[l]);
      if (ReadData_posEdge[l] != rx_crc_p[l][15]) rx_crc_miss = 1'b1;
      if (rx_ddr && (ReadData_negEdge[l] != rx_crc_n[l][15])) rx_crc_miss = 1'b1;
    end
  end
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_state <= RX_IDLE;
      rx_ddr   <= 1'b0;
      rx_cnt   <= '0;
      rx_words <= '0;
      rx_acc   <= '0;
      RxData   <= '0;
      RxValid  <= 1'b0;
      RxDone   <= 1'b0;
      RxErr    <= '0;
`ifdef EMMC_LANE_CRC_EN
      rx_crc_cnt <= '0;
      rx_crc_bad <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        rx_crc_p[l] <= '0;
        rx_crc_n[l] <= '0;
      end
`endif
    end else begin
      RxValid <= 1'b0;
      RxDone  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (RxArm) begin
            rx_words <= (RxWordCount == 10'd0) ? 11'd1024 : {1'b0, RxWordCount};
            rx_ddr   <= DdrMode;
            rx_state <= RX_HUNT;
          end
        end

        RX_HUNT: begin
          if (ReadData_posEdge == '0) begin
            rx_cnt   <= '0;
            rx_state <= RX_DATA;
`ifdef EMMC_LANE_CRC_EN
            rx_crc_bad <= 1'b0;
            for (int unsigned l = 0; l < LANES; l++) begin
              rx_crc_p[l] <= '0;
              rx_crc_n[l] <= '0;
            end
`endif
          end
        end

        RX_DATA: begin
          rx_acc <= rx_next;
`ifdef EMMC_LANE_CRC_EN
          rx_crc_p <= rx_crc_p_nx;
          rx_crc_n <= rx_crc_n_nx;
`endif
          if (rx_wrap) begin
            RxData   <= rx_next;
            RxValid  <= 1'b1;
            rx_cnt   <= '0;
            rx_words <= rx_words - 11'd1;
            if (rx_words == 11'd1) begin
`ifdef EMMC_LANE_CRC_EN
              rx_crc_cnt <= '0;
              rx_state   <= RX_CRC;
`else
              rx_state   <= RX_END;
`endif
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end

`ifdef EMMC_LANE_CRC_EN
        // Received CRC bits are compared against the running CRC MSB, which
        // is then shifted out, so the register walks through its own value.
        RX_CRC: begin
          if (rx_crc_miss) rx_crc_bad <= 1'b1;
          for (int unsigned l = 0; l < LANES; l++) begin
            rx_crc_p[l] <= {rx_crc_p[l][14:0], 1'b0};
            rx_crc_n[l] <= {rx_crc_n[l][14:0], 1'b0};
          end
          rx_crc_cnt <= rx_crc_cnt + 4'd1;
          if (rx_crc_cnt == 4'd15) rx_state <= RX_END;
        end
`endif

        RX_END: begin
`ifdef EMMC_LANE_CRC_EN
          RxErr <= {rx_crc_bad, (ReadData_posEdge != '1)};
`else
          RxErr <= {1'b0, (ReadData_posEdge != '1)};
`endif
          RxDone   <= 1'b1;
          rx_state <= RX_IDLE;
        end

        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_ddr_lane_shifter.sv
// Scoreboard bench for emmc_ddr_lane_shifter (LANES=4, WORD_BITS=8, default
// build without EMMC_LANE_CRC_EN). Stimulus pushes expected line cycles, RX
// words, RX frame-end errors and underrun events into queues; a monitor on
// the falling clock edge pops and compares whenever the DUT presents them.
module tb_emmc_ddr_lane_shifter;
  localparam int L = 4;
  localparam int W = 8;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           DdrMode = 1'b0;
  logic [L*W-1:0] TxData = '0;
  logic           TxValid = 1'b0;
  logic           TxLast = 1'b0;
  logic           TxReady;
  logic           TxUnderrun;
  logic [L-1:0]   WriteData_posEdge;
  logic [L-1:0]   WriteData_negEdge;
  logic           DriveEnable;
  logic [L-1:0]   rpos;
  logic [L-1:0]   rneg;
  logic           RxArm = 1'b0;
  logic [9:0]     RxWordCount = '0;
  logic [L*W-1:0] RxData;
  logic           RxValid;
  logic           RxDone;
  logic [1:0]     RxErr;

  logic           loop = 1'b0;
  logic [L-1:0]   rd_pos = '1;
  logic [L-1:0]   rd_neg = '1;

  assign rpos = loop ? WriteData_posEdge : rd_pos;
  assign rneg = loop ? WriteData_negEdge : rd_neg;

  emmc_ddr_lane_shifter #(.LANES(L), .WORD_BITS(W)) dut (
    .Clk(Clk), .Reset(Reset), .DdrMode(DdrMode),
    .TxData(TxData), .TxValid(TxValid), .TxLast(TxLast), .TxReady(TxReady),
    .TxUnderrun(TxUnderrun),
    .WriteData_posEdge(WriteData_posEdge), .WriteData_negEdge(WriteData_negEdge),
    .DriveEnable(DriveEnable),
    .ReadData_posEdge(rpos), .ReadData_negEdge(rneg),
    .RxArm(RxArm), .RxWordCount(RxWordCount),
    .RxData(RxData), .RxValid(RxValid), .RxDone(RxDone), .RxErr(RxErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic         ready;
    logic [L-1:0] pos;
    logic [L-1:0] neg;
  } line_t;

  line_t          line_q[$];
  logic [L*W-1:0] word_q[$];
  logic [1:0]     done_q[$];
  logic [L:0]     under_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: DUT output %0h with nothing expected", name, act);
  endtask

  // Monitor: compares every DUT presentation against the scoreboard.
  line_t          m_line;
  logic [L*W-1:0] m_word;
  logic [1:0]     m_err;
  logic [L:0]     m_und;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (DriveEnable) begin
        if (line_q.size() == 0) unexpected("line_extra", 64'({TxReady, WriteData_posEdge, WriteData_negEdge}));
        else begin
          m_line = line_q.pop_front();
          check("line", 64'({TxReady, WriteData_posEdge, WriteData_negEdge}), 64'(m_line));
        end
      end
      if (RxValid) begin
        if (word_q.size() == 0) unexpected("rx_word_extra", 64'(RxData));
        else begin
          m_word = word_q.pop_front();
          check("rx_word", 64'(RxData), 64'(m_word));
        end
      end
      if (RxDone) begin
        if (done_q.size() == 0) unexpected("rx_done_extra", 64'(RxErr));
        else begin
          m_err = done_q.pop_front();
          check("rx_done_err", 64'(RxErr), 64'(m_err));
        end
      end
      if (TxUnderrun) begin
        if (under_q.size() == 0) unexpected("underrun_extra", 64'(WriteData_posEdge));
        else begin
          m_und = under_q.pop_front();
          check("underrun_end_bit", 64'({DriveEnable, WriteData_posEdge}), 64'(m_und));
        end
      end
    end
  end

  // Expected line cycles for a frame: start, data chunks, end bit.
  task automatic push_frame(input logic ddr, input logic [L*W-1:0] w0, input logic [L*W-1:0] w1,
                            input int n, input logic ends_last);
    line_t r;
    logic [L*W-1:0] w;
    int per;
    per = ddr ? W/2 : W;
    r.ready = 1'b0; r.pos = '0; r.neg = '0;
    line_q.push_back(r);
    for (int k = 0; k < n; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int c = 0; c < per; c++) begin
        for (int l = 0; l < L; l++) begin
          if (ddr) begin
            r.pos[l] = w[l*W + W-1 - 2*c];
            r.neg[l] = w[l*W + W-2 - 2*c];
          end else begin
            r.pos[l] = w[l*W + W-1 - c];
            r.neg[l] = r.pos[l];
          end
        end
        r.ready = (c == per-1) && ((k != n-1) || !ends_last);
        line_q.push_back(r);
      end
    end
    r.ready = 1'b0; r.pos = '1; r.neg = '1;
    line_q.push_back(r);
  endtask

  // Present one word and hold it until accepted (called at a falling edge).
  task automatic send(input logic [L*W-1:0] w, input logic last);
    int n;
    TxData = w; TxLast = last; TxValid = 1'b1;
    n = 0;
    while (!TxReady && n < 100) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL send_timeout: TxReady low for %0d cycles, required high", n);
    end
    @(negedge Clk);
    TxValid = 1'b0; TxLast = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((line_q.size() + word_q.size() + done_q.size() + under_q.size()) != 0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    n_checks++;
    if (n < 300) n_pass++;
    else $display("FAIL drain_%s: %0d events outstanding, required 0", name,
                  line_q.size() + word_q.size() + done_q.size() + under_q.size());
    repeat (4) @(negedge Clk);
  endtask

  task automatic rx_ddr_word(input logic [L*W-1:0] w);
    for (int c = 0; c < W/2; c++) begin
      for (int l = 0; l < L; l++) begin
        rd_pos[l] = w[l*W + W-1 - 2*c];
        rd_neg[l] = w[l*W + W-2 - 2*c];
      end
      @(negedge Clk);
    end
  endtask

  task automatic arm(input logic ddr, input logic [9:0] cnt);
    DdrMode = ddr; RxWordCount = cnt; RxArm = 1'b1;
    @(negedge Clk);
    RxArm = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  line_t      r;
  logic [9:0] seq;
  logic [3:0] p40 [6];
  logic [3:0] n40 [6];

  initial begin
    // Reset state
    @(negedge Clk);
    check("rst_txready", 64'(TxReady), 64'(1));
    check("rst_drive_en", 64'(DriveEnable), 64'(0));
    check("rst_wd_pos", 64'(WriteData_posEdge), 64'(4'hF));
    check("rst_wd_neg", 64'(WriteData_negEdge), 64'(4'hF));
    check("rst_rxdata", 64'(RxData), 64'(0));
    check("rst_pulses", 64'({RxValid, RxDone, TxUnderrun}), 64'(0));
    check("rst_rxerr", 64'(RxErr), 64'(0));
    @(negedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);

    // SDR, 0xA5 on all lanes: 0,1,0,1,0,0,1,0,1,1 on every lane
    seq = 10'b0101001011;
    for (int i = 0; i < 10; i++) begin
      r.ready = 1'b0; r.pos = {L{seq[9-i]}}; r.neg = r.pos;
      line_q.push_back(r);
    end
    DdrMode = 1'b0;
    send(32'hA5A5_A5A5, 1'b1);
    drain("sdr_a5");

    // DDR, lane0 0xB4, other lanes 0
    p40[0] = 4'h0; n40[0] = 4'h0;
    p40[1] = 4'h1; n40[1] = 4'h0;
    p40[2] = 4'h1; n40[2] = 4'h1;
    p40[3] = 4'h0; n40[3] = 4'h1;
    p40[4] = 4'h0; n40[4] = 4'h0;
    p40[5] = 4'hF; n40[5] = 4'hF;
    for (int i = 0; i < 6; i++) begin
      r.ready = 1'b0; r.pos = p40[i]; r.neg = n40[i];
      line_q.push_back(r);
    end
    DdrMode = 1'b1;
    send(32'h0000_00B4, 1'b1);
    drain("ddr_b4");

    // DDR, two words back-to-back; ready on 4th clock of word 1
    push_frame(1'b1, 32'h3C81_5AE7, 32'h0123_4567, 2, 1'b1);
    DdrMode = 1'b1;
    send(32'h3C81_5AE7, 1'b0);
    send(32'h0123_4567, 1'b1);
    drain("ddr_b2b");

    // SDR underrun after a non-last word
    push_frame(1'b0, 32'hC3F0_0F96, '0, 1, 1'b0);
    under_q.push_back({1'b1, 4'hF});
    DdrMode = 1'b0;
    send(32'hC3F0_0F96, 1'b0);
    drain("underrun");
    check("underrun_idle_ready", 64'({TxReady, DriveEnable}), 64'(2'b10));

    // RX DDR, two words, end bit low on lane 2
    word_q.push_back(32'hE75A_813C);
    word_q.push_back(32'h0FF0_1234);
    done_q.push_back(2'b01);
    arm(1'b1, 10'd2);
    @(negedge Clk);
    rd_pos = '0; rd_neg = '0;
    @(negedge Clk);
    rx_ddr_word(32'hE75A_813C);
    rx_ddr_word(32'h0FF0_1234);
    rd_pos = 4'b1011; rd_neg = '1;
    @(negedge Clk);
    rd_pos = '1; rd_neg = '1;
    drain("rx_ddr_endbit");

    // SDR loopback, two words
    loop = 1'b1;
    push_frame(1'b0, 32'h1122_33CC, 32'hFE01_8077, 2, 1'b1);
    word_q.push_back(32'h1122_33CC);
    word_q.push_back(32'hFE01_8077);
    done_q.push_back(2'b00);
    arm(1'b0, 10'd2);
    send(32'h1122_33CC, 1'b0);
    send(32'hFE01_8077, 1'b1);
    drain("loop_sdr");

    // DDR loopback, one word
    push_frame(1'b1, 32'h6D2B_F009, '0, 1, 1'b1);
    word_q.push_back(32'h6D2B_F009);
    done_q.push_back(2'b00);
    arm(1'b1, 10'd1);
    send(32'h6D2B_F009, 1'b1);
    drain("loop_ddr");

    // Reset in the middle of a frame: lines released at once, no RX result
    push_frame(1'b0, 32'h5555_AAAA, '0, 1, 1'b1);
    arm(1'b0, 10'd1);
    send(32'h5555_AAAA, 1'b1);
    repeat (4) @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    check("midrst_drive_en", 64'(DriveEnable), 64'(0));
    check("midrst_txready", 64'(TxReady), 64'(1));
    check("midrst_wd", 64'({WriteData_posEdge, WriteData_negEdge}), 64'(8'hFF));
    check("midrst_rx", 64'({RxValid, RxDone, RxErr}), 64'(0));
    line_q.delete();
    @(negedge Clk); #1 Reset = 1'b0;
    repeat (30) @(negedge Clk);
    loop = 1'b0;
    drain("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
